// File: rtl/detector_colision.sv
// Tracks obstacle types per digit, runs the player pose FSM and judges each obstacle at digit 0.
// Outputs update the cycle after a step strobe; no backpressure, the generator freezes on W_or_L != 00.
module detector_colision #(
  parameter logic [2:0] GAME        = 3'd3,
  parameter logic [1:0] VIDAS_INI   = 2'd3,
  parameter logic [7:0] META        = 8'd20,
  parameter logic [1:0] SALTO_PASOS = 2'd2,
  parameter logic [1:0] SAMPLE_DLY  = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  presente,
  input  logic        clk_obstaculos,
  input  logic [20:0] display_obs,
  input  logic [3:0]  tipo_obs,
  input  logic        btn_salto,
  input  logic        btn_agacharse,
  output logic [1:0]  W_or_L,
  output logic [7:0]  puntos,
  output logic [1:0]  vidas,
  output logic [1:0]  pose
);

  localparam logic [1:0] PISO     = 2'd0;
  localparam logic [1:0] SALTO    = 2'd1;
  localparam logic [1:0] AGACHADO = 2'd2;

  localparam logic [1:0] WL_PLAY = 2'b00;
  localparam logic [1:0] WL_WIN  = 2'b10;
  localparam logic [1:0] WL_LOSE = 2'b01;

  // [0] first stage, [1] synchronized value, [2] previous synchronized value
  logic [2:0] obs_sync;
  logic [2:0] salto_sync;
  logic [1:0] agach_sync;

  logic       obs_rise;
  logic       salto_rise;
  logic       agach;
  logic [1:0] dly_cnt;
  logic       paso;
  logic       juicio;

  logic [2:0] tipo_sh;
  logic [2:0] valido_sh;
  logic [1:0] salto_cnt;

  logic       en_juego;
  logic       jugando;
  logic       juzga;
  logic       choque;
  logic [8:0] puntos_inc;
  logic       unused_bits;

  assign obs_rise    = obs_sync[1] & ~obs_sync[2];
  assign salto_rise  = salto_sync[1] & ~salto_sync[2];
  assign agach       = agach_sync[1];
  assign paso        = (dly_cnt == 2'd1) && !obs_rise;
  assign unused_bits = ^{tipo_obs[3:1], display_obs[13:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      obs_sync   <= 3'b000;
      salto_sync <= 3'b000;
      agach_sync <= 2'b00;
      dly_cnt    <= 2'd0;
      juicio     <= 1'b0;
    end else begin
      obs_sync   <= {obs_sync[1:0], clk_obstaculos};
      salto_sync <= {salto_sync[1:0], btn_salto};
      agach_sync <= {agach_sync[0], btn_agacharse};
      if (obs_rise)
        dly_cnt <= SAMPLE_DLY;
      else if (dly_cnt != 2'd0)
        dly_cnt <= dly_cnt - 2'd1;
      juicio <= paso;
    end
  end

  assign en_juego   = (presente == GAME);
  assign jugando    = en_juego && (W_or_L == WL_PLAY);
  assign juzga      = juicio && jugando && valido_sh[0] && (display_obs[6:0] != 7'd0);
  assign choque     = tipo_sh[0] ? (pose != AGACHADO) : (pose != SALTO);
  assign puntos_inc = {1'b0, puntos} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst || !en_juego) begin
      W_or_L    <= WL_PLAY;
      puntos    <= 8'd0;
      vidas     <= VIDAS_INI;
      pose      <= PISO;
      salto_cnt <= 2'd0;
      tipo_sh   <= 3'b000;
      valido_sh <= 3'b000;
    end else if (jugando) begin
      // index 2 is the entry digit, index 0 the player column
      if (paso) begin
        tipo_sh   <= {tipo_obs[0], tipo_sh[2:1]};
        valido_sh <= {display_obs[20:14] != 7'd0, valido_sh[2:1]};
      end
      if (juzga) begin
        if (choque) begin
          vidas <= vidas - 2'd1;
          if (vidas == 2'd1)
            W_or_L <= WL_LOSE;
        end else begin
          if (puntos != 8'hFF)
            puntos <= puntos + 8'd1;
          if (puntos_inc == {1'b0, META})
            W_or_L <= WL_WIN;
        end
      end
      case (pose)
        PISO: begin
          if (salto_rise) begin
            pose      <= SALTO;
            salto_cnt <= SALTO_PASOS;
          end else if (agach) begin
            pose <= AGACHADO;
          end
        end
        SALTO: begin
          // counted on the judgment cycle so that step is still judged airborne
          if (juicio) begin
            if (salto_cnt <= 2'd1) begin
              pose      <= PISO;
              salto_cnt <= 2'd0;
            end else begin
              salto_cnt <= salto_cnt - 2'd1;
            end
          end
        end
        AGACHADO: begin
          if (!agach)
            pose <= PISO;
        end
        default: pose <= PISO;
      endcase
    end
  end

endmodule
